// File: rtl/ethernet_header_pkg.sv
//============================================================================
// Module   : ethernet_header_pkg
// Brief    : Ethernet header layout, frame size limits and assembler states.
// Revision : 1.0
//============================================================================
`default_nettype none

package ethernet_header_pkg;

   localparam int ETH_HEADER_BYTES = 14;
   localparam int ETH_MIN_PAYLOAD  = 46;
   localparam int ETH_MAX_PAYLOAD  = 1500;

   // Destination sits in the low bits so octet n of the wire is bits [8n+7:8n];
   // element 0 of every field is the first of its octets on the wire.
   typedef struct packed {
      logic [1:0][7:0] ether_type;
      logic [5:0][7:0] mac_source;
      logic [5:0][7:0] mac_destination;
   } ethernet_header;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HEADER  = 3'd1,
      PAYLOAD = 3'd2,
      PAD     = 3'd3,
      DROP    = 3'd4
   } eth_asm_state_t;

endpackage

`default_nettype wire

// File: rtl/eth_frame_assembler.sv
//============================================================================
// Module   : eth_frame_assembler
// Brief    : Emits 14 header octets, then payload, then zero pad to minimum.
// Revision : 1.0
//============================================================================
`default_nettype none

module eth_frame_assembler
   import ethernet_header_pkg::*;
#(
   parameter int MIN_PAYLOAD_BYTES = ETH_MIN_PAYLOAD,
   parameter int MAX_PAYLOAD_BYTES = ETH_MAX_PAYLOAD
) (
   input  logic           clk,
   input  logic           reset,
   input  ethernet_header hdr_in,
   input  logic           hdr_valid,
   output logic           hdr_ready,
   input  logic [7:0]     s_axis_tdata,
   input  logic           s_axis_tvalid,
   input  logic           s_axis_tlast,
   output logic           s_axis_tready,
   output logic [7:0]     m_axis_tdata,
   output logic           m_axis_tvalid,
   output logic           m_axis_tlast,
   input  logic           m_axis_tready,
   output logic           oversize_err
);

   localparam logic [10:0] c_MIN_CNT      = 11'(MIN_PAYLOAD_BYTES);
   localparam logic [10:0] c_MAX_CNT      = 11'(MAX_PAYLOAD_BYTES);
   localparam logic [3:0]  c_LAST_HDR_IDX = 4'(ETH_HEADER_BYTES - 1);

   eth_asm_state_t                r_state;
   eth_asm_state_t                w_state_nxt;
   logic [8*ETH_HEADER_BYTES-1:0] r_hdr;
   logic [3:0]                    r_idx;
   logic [3:0]                    w_idx_nxt;
   logic [10:0]                   r_pay_cnt;
   logic [10:0]                   w_pay_cnt_nxt;
   logic [10:0]                   w_pay_cnt_inc;
   logic                          r_oversize;
   logic                          w_oversize_nxt;
   logic                          w_load_hdr;
   logic                          w_pay_hs;
   logic                          w_at_max;

   assign w_pay_cnt_inc = r_pay_cnt + 11'd1;
   assign w_pay_hs      = s_axis_tvalid & m_axis_tready;
   assign w_at_max      = (w_pay_cnt_inc == c_MAX_CNT);
   assign oversize_err  = r_oversize;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_hdr      <= '0;
         r_idx      <= '0;
         r_pay_cnt  <= '0;
         r_oversize <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_pay_cnt  <= w_pay_cnt_nxt;
         r_oversize <= w_oversize_nxt;
         if (w_load_hdr) begin
            r_hdr <= hdr_in;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_pay_cnt_nxt  = r_pay_cnt;
      w_oversize_nxt = 1'b0;
      w_load_hdr     = 1'b0;
      hdr_ready      = 1'b0;
      s_axis_tready  = 1'b0;
      m_axis_tvalid  = 1'b0;
      m_axis_tdata   = 8'h00;
      m_axis_tlast   = 1'b0;

      case (r_state)
         IDLE: begin
            // Gated so every output stays low for the whole reset assertion.
            hdr_ready = ~reset;
            if (hdr_valid) begin
               w_load_hdr    = 1'b1;
               w_idx_nxt     = '0;
               w_pay_cnt_nxt = '0;
               w_state_nxt   = HEADER;
            end
         end

         HEADER: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = r_hdr[{r_idx, 3'b000} +: 8];
            if (m_axis_tready) begin
               w_idx_nxt = r_idx + 4'd1;
               if (r_idx == c_LAST_HDR_IDX) begin
                  w_state_nxt = PAYLOAD;
               end
            end
         end

         PAYLOAD: begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
            s_axis_tready = m_axis_tready;
            m_axis_tlast  = (s_axis_tlast && (w_pay_cnt_inc >= c_MIN_CNT)) || w_at_max;
            if (w_pay_hs) begin
               w_pay_cnt_nxt = w_pay_cnt_inc;
               if (s_axis_tlast) begin
                  w_state_nxt = (w_pay_cnt_inc >= c_MIN_CNT) ? IDLE : PAD;
               end else if (w_at_max) begin
                  w_oversize_nxt = 1'b1;
                  w_state_nxt    = DROP;
               end
            end
         end

         PAD: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = (w_pay_cnt_inc == c_MIN_CNT);
            if (m_axis_tready) begin
               w_pay_cnt_nxt = w_pay_cnt_inc;
               if (w_pay_cnt_inc == c_MIN_CNT) begin
                  w_state_nxt = IDLE;
               end
            end
         end

         DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               w_state_nxt = IDLE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_eth_frame_assembler.sv
//============================================================================
// Module   : tb_eth_frame_assembler
// Brief    : Randomised self-checking bench for eth_frame_assembler.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_eth_frame_assembler;
   import ethernet_header_pkg::*;

   localparam int c_MIN = ETH_MIN_PAYLOAD;
   localparam int c_MAX = ETH_MAX_PAYLOAD;

   logic           clk           = 1'b0;
   logic           reset         = 1'b1;
   ethernet_header hdr_in        = '0;
   logic           hdr_valid     = 1'b0;
   logic [7:0]     s_axis_tdata  = 8'h00;
   logic           s_axis_tvalid = 1'b0;
   logic           s_axis_tlast  = 1'b0;
   logic           m_axis_tready = 1'b0;
   logic           hdr_ready;
   logic           s_axis_tready;
   logic [7:0]     m_axis_tdata;
   logic           m_axis_tvalid;
   logic           m_axis_tlast;
   logic           oversize_err;

   eth_frame_assembler dut (
      .clk           (clk),
      .reset         (reset),
      .hdr_in        (hdr_in),
      .hdr_valid     (hdr_valid),
      .hdr_ready     (hdr_ready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .oversize_err  (oversize_err)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         ovf_seen = 0;
   logic [7:0] pay_q[$];
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int         stall_viol;
   bit         timed_out;
   logic       rdy_at_last;

   always @(negedge clk) if (oversize_err) ovf_seen <= ovf_seen + 1;

   initial begin
      #950_000;
      $display("FAIL watchdog: simulation time exhausted, expected completion");
      $fatal(1, "watchdog");
   end

   // Reference frame: header octets in wire order, payload clipped at MAX,
   // zero pad to MIN, tlast on the final octet only.
   function automatic void build_expected(input logic [111:0] h);
      int n, tot;
      exp_q.delete();
      for (int i = 0; i < ETH_HEADER_BYTES; i++) exp_q.push_back({1'b0, h[8*i +: 8]});
      n   = (pay_q.size() > c_MAX) ? c_MAX : pay_q.size();
      tot = (n < c_MIN) ? c_MIN : n;
      for (int i = 0; i < tot; i++)
         exp_q.push_back({(i == tot - 1), (i < n) ? pay_q[i] : 8'h00});
   endfunction

   function automatic int first_diff();
      for (int i = 0; i < exp_q.size(); i++)
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) return i;
      if (got_q.size() != exp_q.size()) return exp_q.size();
      return -1;
   endfunction

   function automatic logic [111:0] rand_hdr();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[111:0];
   endfunction

   task automatic fill_payload(input int len);
      pay_q.delete();
      for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // Drives one header plus pay_q and records every accepted output octet.
   task automatic run_frame(input logic [111:0] h, input bit rr, input bit rv);
      int len, glim;
      bit d_hdr, d_pay, d_mon;
      len = pay_q.size();
      glim = len * 10 + 400;
      got_q.delete();
      stall_viol = 0; timed_out = 0; rdy_at_last = 1'bx;
      d_hdr = 0; d_pay = 0; d_mon = 0;
      fork
         begin
            bit ok; int g;
            ok = 0; g = 0;
            hdr_in = ethernet_header'(h); hdr_valid = 1'b1;
            while (!ok && g < 200) begin
               @(negedge clk); ok = hdr_ready;
               @(posedge clk); #1; g++;
            end
            hdr_valid = 1'b0;
            if (!ok) timed_out = 1;
            d_hdr = 1;
         end
         begin
            int i, g; bit acc, pend;
            i = 0; g = 0; pend = 0;
            while (i < len && g < glim) begin
               if (!pend && rv && $urandom_range(0, 2) == 0) s_axis_tvalid = 1'b0;
               else begin
                  s_axis_tvalid = 1'b1; s_axis_tdata = pay_q[i]; s_axis_tlast = (i == len - 1);
               end
               @(negedge clk); acc = s_axis_tvalid && s_axis_tready; pend = s_axis_tvalid && !acc;
               @(posedge clk); #1;
               if (acc) i++;
               g++;
            end
            s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
            if (i < len) timed_out = 1;
            d_pay = 1;
         end
         begin
            bit fin, pst; logic [7:0] pd; logic plst; int g;
            fin = 0; pst = 0; pd = 8'h00; plst = 1'b0; g = 0;
            while (!fin && g < glim) begin
               @(negedge clk);
               if (pst && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== plst)) stall_viol++;
               pst = m_axis_tvalid && !m_axis_tready; pd = m_axis_tdata; plst = m_axis_tlast;
               if (m_axis_tvalid && m_axis_tready) begin
                  got_q.push_back({m_axis_tlast, m_axis_tdata});
                  if (m_axis_tlast) begin fin = 1; rdy_at_last = hdr_ready; end
               end
               g++;
            end
            if (!fin) timed_out = 1;
            d_mon = 1;
         end
         begin
            while (!(d_hdr && d_pay && d_mon)) begin
               m_axis_tready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
               @(posedge clk); #1;
            end
         end
      join
      build_expected(h);
   endtask

   task automatic test_reset;
      reset = 1'b1; hdr_valid = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if ({hdr_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, oversize_err} !== 13'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b required all zero",
                  {hdr_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, oversize_err});
      end
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (hdr_ready !== 1'b1) begin
         n_errors++; $display("FAIL reset_release_ready: got %b required 1", hdr_ready);
      end
   endtask

   task automatic test_min_frame;
      ethernet_header h;
      int d, nl;
      h.mac_destination = {6{8'hFF}};
      h.mac_source      = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
      h.ether_type      = {8'h00, 8'h08};
      pay_q.delete();
      for (int i = 0; i < 46; i++) pay_q.push_back(8'(i));
      run_frame(h, 0, 0);
      n_checks++;
      if (got_q.size() != 60) begin n_errors++; $display("FAIL min_len: got %0d required 60", got_q.size()); end
      d = first_diff();
      n_checks++;
      if (d >= 0) begin n_errors++; $display("FAIL min_data: first difference at octet %0d", d); end
      n_checks++;
      if (got_q.size() < 6 || got_q[0] !== 9'h0FF || got_q[5] !== 9'h0FF || got_q[3] !== 9'h0FF) begin
         n_errors++; $display("FAIL min_dst_bcast: octets 0-5 are not FF, size %0d", got_q.size());
      end
      nl = 0;
      foreach (got_q[i]) if (got_q[i][8]) nl++;
      n_checks++;
      if (nl != 1 || got_q.size() == 0 || !got_q[got_q.size()-1][8]) begin
         n_errors++; $display("FAIL min_tlast: got %0d tlast octets required exactly 1 at the end", nl);
      end
   endtask

   task automatic test_short_pad;
      logic [111:0] h;
      int d;
      h = rand_hdr();
      fill_payload(10);
      run_frame(h, 0, 0);
      d = first_diff();
      n_checks++;
      if (got_q.size() != 60 || d >= 0) begin
         n_errors++; $display("FAIL pad10_frame: got %0d octets (first diff %0d) required 60 matching", got_q.size(), d);
      end
      n_checks++;
      if (rdy_at_last !== 1'b0) begin n_errors++; $display("FAIL pad10_ready_at_last: got %b required 0", rdy_at_last); end
      n_checks++;
      if (hdr_ready !== 1'b1) begin n_errors++; $display("FAIL pad10_ready_after: got %b required 1", hdr_ready); end
   endtask

   task automatic test_one_byte;
      logic [111:0] h;
      int d, npad;
      h = rand_hdr();
      pay_q.delete(); pay_q.push_back(8'h5A);
      run_frame(h, 0, 0);
      d = first_diff();
      n_checks++;
      if (got_q.size() != 60 || d >= 0) begin
         n_errors++; $display("FAIL one_byte_frame: got %0d octets (first diff %0d) required 60 matching", got_q.size(), d);
      end
      npad = 0;
      for (int i = 15; i < got_q.size(); i++) if (got_q[i][7:0] == 8'h00) npad++;
      n_checks++;
      if (npad != 45) begin n_errors++; $display("FAIL one_byte_pad: got %0d zero pad octets required 45", npad); end
   endtask

   task automatic test_max_boundary;
      logic [111:0] h;
      int d, o0;
      h = rand_hdr();
      fill_payload(c_MAX);
      o0 = ovf_seen;
      run_frame(h, 0, 0);
      d = first_diff();
      n_checks++;
      if (got_q.size() != 1514 || d >= 0) begin
         n_errors++; $display("FAIL max_exact_frame: got %0d octets (first diff %0d) required 1514", got_q.size(), d);
      end
      @(negedge clk);
      n_checks++;
      if (ovf_seen - o0 != 0) begin n_errors++; $display("FAIL max_exact_err: got %0d pulses required 0", ovf_seen - o0); end
      @(posedge clk); #1;
   endtask

   task automatic test_oversize;
      logic [111:0] h;
      int d, o0;
      h = rand_hdr();
      fill_payload(1600);
      o0 = ovf_seen;
      run_frame(h, 0, 0);
      d = first_diff();
      n_checks++;
      if (got_q.size() != 1514 || d >= 0 || timed_out) begin
         n_errors++; $display("FAIL oversize_frame: got %0d octets (first diff %0d, timeout %0d) required 1514", got_q.size(), d, timed_out);
      end
      n_checks++;
      if (ovf_seen - o0 != 1) begin n_errors++; $display("FAIL oversize_err: got %0d pulses required 1", ovf_seen - o0); end
      n_checks++;
      if (hdr_ready !== 1'b1) begin n_errors++; $display("FAIL oversize_drained: hdr_ready %b required 1", hdr_ready); end
   endtask

   task automatic test_random;
      logic [111:0] h;
      int d, o0, len, bad_frames, bad_err, bad_stall;
      bad_frames = 0; bad_err = 0; bad_stall = 0;
      for (int f = 0; f < 200; f++) begin
         h = rand_hdr();
         len = (f % 100 == 50) ? $urandom_range(c_MAX + 1, c_MAX + 3) : $urandom_range(1, 80);
         fill_payload(len);
         o0 = ovf_seen;
         run_frame(h, 1, 1);
         @(negedge clk);
         d = first_diff();
         n_checks++;
         if (d >= 0 || timed_out) begin
            n_errors++; bad_frames++;
            if (bad_frames < 5)
               $display("FAIL rand_frame %0d: len %0d got %0d octets, first diff %0d, timeout %0d, required %0d",
                        f, len, got_q.size(), d, timed_out, exp_q.size());
         end
         n_checks++;
         if (ovf_seen - o0 != ((len > c_MAX) ? 1 : 0)) begin
            n_errors++; bad_err++;
            if (bad_err < 5) $display("FAIL rand_err %0d: got %0d pulses for len %0d", f, ovf_seen - o0, len);
         end
         n_checks++;
         if (stall_viol != 0) begin
            n_errors++; bad_stall++;
            if (bad_stall < 5) $display("FAIL rand_stall %0d: got %0d changes while stalled required 0", f, stall_viol);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid;
      logic [111:0] h;
      int d, seen, g;
      // Abort while header octet 7 is presented.
      h = rand_hdr();
      m_axis_tready = 1'b1; s_axis_tvalid = 1'b0;
      hdr_in = ethernet_header'(h); hdr_valid = 1'b1;
      @(posedge clk); #1; hdr_valid = 1'b0;
      repeat (7) @(posedge clk); #1;
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== h[63:56]) begin
         n_errors++; $display("FAIL hdr_idx7: got %h required %h", m_axis_tdata, h[63:56]);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({hdr_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, oversize_err} !== 13'd0) begin
         n_errors++; $display("FAIL reset_in_header: got %b required all zero",
                              {hdr_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, oversize_err});
      end
      reset = 1'b0;
      h = rand_hdr(); fill_payload(20);
      run_frame(h, 1, 1);
      d = first_diff();
      n_checks++;
      if (d >= 0) begin n_errors++; $display("FAIL after_hdr_reset: first difference at octet %0d of %0d", d, got_q.size()); end

      // Abort during the zero pad of a 1-octet frame.
      h = rand_hdr();
      m_axis_tready = 1'b1;
      hdr_in = ethernet_header'(h); hdr_valid = 1'b1;
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'hC3; s_axis_tlast = 1'b1;
      @(posedge clk); #1; hdr_valid = 1'b0;
      seen = 0; g = 0;
      while (seen < 20 && g < 100) begin
         @(negedge clk);
         if (m_axis_tvalid && m_axis_tready) seen++;
         if (s_axis_tvalid && s_axis_tready) begin @(posedge clk); #1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; end
         else begin @(posedge clk); #1; end
         g++;
      end
      n_checks++;
      if (seen != 20 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h00 || s_axis_tready !== 1'b0) begin
         n_errors++; $display("FAIL pad_reach: got %0d octets, tvalid %b data %h, required 20 then pad", seen, m_axis_tvalid, m_axis_tdata);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({hdr_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, oversize_err} !== 13'd0) begin
         n_errors++; $display("FAIL reset_in_pad: got %b required all zero",
                              {hdr_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, oversize_err});
      end
      reset = 1'b0;
      h = rand_hdr(); fill_payload(5);
      run_frame(h, 0, 0);
      d = first_diff();
      n_checks++;
      if (d >= 0) begin n_errors++; $display("FAIL after_pad_reset: first difference at octet %0d of %0d", d, got_q.size()); end
   endtask

   initial begin
      test_reset;
      test_min_frame;
      test_short_pad;
      test_one_byte;
      test_max_boundary;
      test_oversize;
      test_random;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
